// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped machine timer: register offsets,
// CTRL field layout and reset values.
package timer_pkg;

  localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
  localparam logic [4:0] CTRL_OFF        = 5'h10;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;
  localparam int PRESC_LSB   = 8;
  localparam int PRESC_MSB   = 23;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Readback image of CTRL; unused bits read as zero.
  function automatic logic [31:0] pack_ctrl(input logic en, input logic ie,
                                            input logic [15:0] presc);
    logic [31:0] v;
    v = '0;
    v[CTRL_EN_BIT] = en;
    v[CTRL_IE_BIT] = ie;
    v[PRESC_MSB:PRESC_LSB] = presc;
    return v;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick when the count
// reaches presc, so the tick period is presc+1 cycles.
module timer_prescaler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = en && (cnt == presc);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped 64-bit machine timer with compare interrupt, prescaled tick
// and an anti-tear shadow for the high word of mtime.
module timer_dev
  import timer_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    timer_irq_o
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] shadow_hi;
  logic        ctrl_en;
  logic        ctrl_ie;
  logic [15:0] ctrl_presc;
  logic        tick;
  logic [4:0]  off;
  logic        wr;
  logic        rd;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign off = {device_addr_i[4:2], 2'b00};
  assign wr  = device_req_i && device_we_i;
  assign rd  = device_req_i && !device_we_i;
  assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

  timer_prescaler u_presc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ctrl_en),
    .clr   (wr && (off == CTRL_OFF)),
    .presc (ctrl_presc),
    .tick  (tick)
  );

  // MTIME_HI deliberately returns the shadow captured by the last MTIME_LO read.
  always_comb begin
    rd_mux = '0;
    case (off)
      MTIME_LO_OFF:    rd_mux = mtime[31:0];
      MTIME_HI_OFF:    rd_mux = shadow_hi;
      MTIMECMP_LO_OFF: rd_mux = mtimecmp[31:0];
      MTIMECMP_HI_OFF: rd_mux = mtimecmp[63:32];
      CTRL_OFF:        rd_mux = pack_ctrl(ctrl_en, ctrl_ie, ctrl_presc);
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime          <= '0;
      mtimecmp       <= MTIMECMP_RST;
      shadow_hi      <= '0;
      ctrl_en        <= 1'b0;
      ctrl_ie        <= 1'b0;
      ctrl_presc     <= '0;
      device_rdata_o <= '0;
      timer_irq_o    <= 1'b0;
    end else begin
      // A software write to either half wins over a coincident tick.
      if (wr && (off == MTIME_LO_OFF)) begin
        mtime[31:0] <= device_wdata_i;
      end else if (wr && (off == MTIME_HI_OFF)) begin
        mtime[63:32] <= device_wdata_i;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr && (off == MTIMECMP_LO_OFF)) mtimecmp[31:0]  <= device_wdata_i;
      if (wr && (off == MTIMECMP_HI_OFF)) mtimecmp[63:32] <= device_wdata_i;

      if (wr && (off == CTRL_OFF)) begin
        ctrl_en    <= device_wdata_i[CTRL_EN_BIT];
        ctrl_ie    <= device_wdata_i[CTRL_IE_BIT];
        ctrl_presc <= device_wdata_i[PRESC_MSB:PRESC_LSB];
      end

      if (rd) begin
        device_rdata_o <= rd_mux;
        if (off == MTIME_LO_OFF) shadow_hi <= mtime[63:32];
      end

      timer_irq_o <= ctrl_ie && (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register table, counting, wrap,
// collision, interrupt and reset sequences with a read-data scoreboard.
`timescale 1ns/1ps
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    int          tol;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t cur;

  timer_dev #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_wdata_i (wdata),
    .device_rdata_o (rdata),
    .timer_irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read-data scoreboard: every read issued pushes an expectation; the value
  // is compared one cycle later when rdata is updated.
  always @(posedge clk) begin
    if (!rst && req && !we) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
      end else begin
        logic [31:0] d;
        cur = sb.pop_front();
        d = (rdata > cur.exp) ? rdata - cur.exp : cur.exp - rdata;
        checks++;
        if (^rdata === 1'bx || d > cur.tol) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (+/-%0d)", cur.name, rdata, cur.exp, cur.tol);
        end
      end
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] e, input int tol, input string nm);
    exp_t x;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    if (!w) begin
      x.exp = e; x.tol = tol; x.name = nm;
      sb.push_back(x);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    access(1'b1, a, d, 32'h0, 0, "wr");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    access(1'b0, a, 32'h0, e, 0, nm);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    // Reset values, map, CTRL masking, unmapped offsets, anti-tear shadow.
    add(0, 32'h00, 0, 32'h0);
    add(0, 32'h04, 0, 32'h0);
    add(0, 32'h08, 0, 32'hFFFF_FFFF);
    add(0, 32'h0C, 0, 32'hFFFF_FFFF);
    add(0, 32'h10, 0, 32'h0);
    add(0, 32'h1C, 0, 32'h0);
    add(0, 32'h14, 0, 32'h0);
    add(1, 32'h08, 32'h0000_1234, 0);
    add(1, 32'h0C, 32'hABCD_0000, 0);
    add(1, 32'h10, 32'hFFFF_FFFC, 0);
    add(1, 32'h1C, 32'hDEAD_BEEF, 0);
    add(1, 32'h04, 32'h0000_0007, 0);
    add(1, 32'h00, 32'h0000_0009, 0);
    add(0, 32'h08, 0, 32'h0000_1234);
    add(0, 32'h0C, 0, 32'hABCD_0000);
    add(0, 32'h10, 0, 32'h00FF_FF00);
    add(0, 32'h1C, 0, 32'h0);
    add(0, 32'h00, 0, 32'h0000_0009);
    add(0, 32'h04, 0, 32'h0000_0007);
    add(1, 32'h04, 32'h0000_0008, 0);
    add(0, 32'h04, 0, 32'h0000_0007);
    add(0, 32'h20, 0, 32'h0000_0009);
    add(0, 32'h24, 0, 32'h0000_0008);

    do_reset();
    foreach (tbl[i]) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp, 0, $sformatf("tbl%0d", i));
    end
    idle(2);
    chk("irq_idle", {31'b0, irq}, 32'h0);

    // PRESC=3: one tick every 4 cycles.
    do_reset();
    wr(32'h10, 32'h0000_0301);
    idle(40);
    for (int k = 41; k <= 52; k++) begin
      access(1'b0, 32'h00, 32'h0, (k - 1) / 4, (k == 41) ? 1 : 0, $sformatf("count_k%0d", k));
    end
    idle(1);

    // Low-word overflow carries into the high word on exactly one tick.
    wr(32'h10, 32'h0);
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h04, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h10, 32'h0);
    rd(32'h00, 32'h0, "wrap_lo");
    rd(32'h04, 32'h1, "wrap_hi");
    idle(1);

    // MTIME_LO write coinciding with a tick.
    wr(32'h04, 32'h0000_0055);
    wr(32'h00, 32'h0000_0020);
    wr(32'h10, 32'h0000_0301);
    idle(3);
    wr(32'h00, 32'h0000_0100);
    wr(32'h10, 32'h0);
    rd(32'h00, 32'h0000_0100, "collide_lo");
    rd(32'h04, 32'h0000_0055, "collide_hi");
    idle(1);

    // Interrupt: rises when mtime reaches 5, falls after compare/IE changes.
    do_reset();
    wr(32'h08, 32'h5);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h3);
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("irq_rise_k%0d", k), {31'b0, irq}, (k >= 6) ? 32'h1 : 32'h0);
    end
    wr(32'h08, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("irq_hold_cmpwr", {31'b0, irq}, 32'h1);
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    chk("irq_fall_cmp", {31'b0, irq}, 32'h0);
    wr(32'h08, 32'h0);
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    chk("irq_rerise", {31'b0, irq}, 32'h1);
    wr(32'h10, 32'h1);
    @(posedge clk); #1;
    chk("irq_hold_iewr", {31'b0, irq}, 32'h1);
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    chk("irq_fall_ie", {31'b0, irq}, 32'h0);

    // Reset mid-count with a concurrent write; first access right after.
    wr(32'h10, 32'h3);
    rd(32'h10, 32'h3, "ctrl_before_rst");
    idle(3);
    chk("irq_before_rst", {31'b0, irq}, 32'h1);
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'h77;
    @(posedge clk); #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h00;
    x.exp = 32'h0; x.tol = 0; x.name = "post_rst_lo";
    sb.push_back(x);
    rd(32'h04, 32'h0, "post_rst_hi");
    rd(32'h08, 32'hFFFF_FFFF, "post_rst_cmplo");
    rd(32'h0C, 32'hFFFF_FFFF, "post_rst_cmphi");
    rd(32'h10, 32'h0, "post_rst_ctrl");
    idle(2);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameter DataWidth, default 32, register and data-bus width; only 32 is supported.
REQ-002 Parameter AddressWidth, default 32, device address width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 device_req_i  input  1  access request from bus slave port, one-cycle pulse per access.
REQ-006 device_addr_i  input  AddressWidth  byte address; only bits [4:2] decoded.
REQ-007 device_we_i  input  1  1 = write, 0 = read; valid when device_req_i=1.
REQ-008 device_wdata_i  input  DataWidth  write data; full-word writes only, no byte enables.
REQ-009 device_rdata_o  output  DataWidth  registered read data.
REQ-010 timer_irq_o  output  1  registered timer interrupt, level.

Function
REQ-011 Register map (offset, access): 0x00 MTIME_LO rw; 0x04 MTIME_HI rw; 0x08 MTIMECMP_LO rw; 0x0C MTIMECMP_HI rw; 0x10 CTRL rw. Any other offset: reads return 0, writes are ignored.
REQ-012 CTRL fields: bit0 EN (count enable); bit1 IE (interrupt enable); bits[23:8] PRESC (16-bit); other bits read 0.
REQ-013 Writes: when device_req_i=1 and device_we_i=1, the addressed register updates at the next rising edge.
REQ-014 Reads: when device_req_i=1 and device_we_i=0, device_rdata_o holds the addressed value on the cycle after the request (1-cycle latency). It is held until the next read.
REQ-015 Writes and cycles with no request leave device_rdata_o unchanged.
REQ-016 Prescaler: 16-bit counter; when EN=1, it increments each cycle. When it equals PRESC, it clears and produces a one-cycle tick; PRESC=0 gives a tick every cycle.
REQ-017 When EN=0, the prescaler counter clears to 0 and no tick occurs.
REQ-018 Writing CTRL clears the prescaler counter.
REQ-019 On a tick, the 64-bit mtime increments by 1 with modular wrap: 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-020 Write/tick collision: a write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority. The written half takes the write data; the other half keeps its pre-tick value (no increment that cycle).
REQ-021 Anti-tear on MTIME_LO read: the read returns mtime[31:0] and latches mtime[63:32] into a shadow register.
REQ-022 MTIME_HI read returns the shadow value, not the live high word.
REQ-023 timer_irq_o is registered as IE && (mtime >= mtimecmp), unsigned 64-bit compare. It asserts one cycle after the condition becomes true.
REQ-024 timer_irq_o deasserts one cycle after a write makes the condition false, or after IE is cleared.
REQ-025 A read of any register in the same cycle as a tick returns the pre-tick value.

Reset
REQ-026 On rst_i=1 at a rising edge, the following clear to 0: mtime, shadow, CTRL, prescaler counter, device_rdata_o and timer_irq_o.
REQ-027 mtimecmp resets to 0xFFFF_FFFF_FFFF_FFFF.
REQ-028 Reset asserted mid-operation overrides any concurrent write, read or tick in that cycle.
REQ-029 After reset deasserts, the first access is accepted in the following cycle.

Structure
REQ-030 Package timer_pkg holds: register offsets (MTIME_LO..CTRL), CTRL bit positions, the PRESC field range, and the mtimecmp reset constant.
REQ-031 The prescaler is a sub-module, timer_prescaler: inputs clk_i, rst_i, en, clr, presc[15:0]; output tick.
REQ-032 The remaining logic (register file, decode, compare, read mux) lives in timer_dev.

Verification
REQ-033 Reset, then read all five offsets -> rdata 0,0,0xFFFFFFFF,0xFFFFFFFF,0; timer_irq_o=0.
REQ-034 Write CTRL=0x0000_0301 (EN, PRESC=3), wait 40 cycles, read MTIME_LO -> 10 ±1; no increment between consecutive ticks less than 4 cycles apart.
REQ-035 Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, CTRL=0x1, one tick -> MTIME_LO read 0, MTIME_HI read 1.
REQ-036 Write MTIMECMP=5 (HI=0), CTRL=0x3, PRESC=0 -> timer_irq_o rises the cycle after mtime reaches 5. Then write MTIMECMP_LO=0xFFFF_FFFF -> irq falls one cycle later.
REQ-037 Tick and MTIME_LO write of 0x100 in the same cycle -> MTIME_LO reads 0x100, high word unchanged.
REQ-038 Read of unmapped offset 0x1C -> rdata 0. Write 0x1C -> no register changes. Assert rst_i during counting -> all values at reset state next cycle.
